time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DEB_MS, default 20, meaning consecutive stable 1 kHz samples before a button level is accepted.
REQ-002 SHALL have parameter BLINK_MS, default 250, meaning half-period of the set-mode digit blink, in ms.
REQ-003 SHALL have parameter TIMEOUT_MS, default 10000, meaning idle time in a set state before abandoning without a load.
REQ-004 SHALL have parameter RPT_DLY_MS, default 500, meaning the inc hold time before auto-repeat starts.
REQ-005 SHALL have parameter RPT_MS, default 200, meaning the auto-repeat period.
REQ-006 SHALL have port MHz  input  1  sole system clock (10 MHz); all logic on posedge MHz.
REQ-007 SHALL have port Reset  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port tick_1khz  input  1  one-MHz-cycle strobe at 1 kHz.
REQ-009 SHALL have port btn_mode  input  1  raw mode push-button, active-high, asynchronous.
REQ-010 SHALL have port btn_inc  input  1  raw increment push-button, active-high, asynchronous.
REQ-011 SHALL have port cur_h1, cur_h2, cur_m1, cur_m2  input  1/4/3/4  live time digits from the time counter.
REQ-012 SHALL have port run_en  output  1  time counter count enable.
REQ-013 SHALL have port load  output  1  one-cycle strobe: counter takes ld_* and clears seconds.
REQ-014 SHALL have port ld_h1, ld_h2, ld_m1, ld_m2  output  1/4/3/4  values to load.
REQ-015 SHALL have port blank  output  6  per-digit blank for the display scan; bit0=H1, bit1=H2, bit2=M1, bit3=M2, bit4=S1, bit5=S2.
REQ-016 SHALL have port mode  output  2  current state code.

Function
REQ-017 SHALL pass each button through a 2-FF synchronizer, then btn_debounce: the accepted level changes only after DEB_MS consecutive equal samples, taken on tick_1khz.
REQ-018 SHALL generate a one-cycle press pulse on each 0->1 of the debounced level; releases produce nothing.
REQ-019 SHALL auto-repeat inc: while debounced inc stays high, extra press pulses occur RPT_DLY_MS after the press, then every RPT_MS.
REQ-020 SHALL implement states RUN=0, SET_H=1, SET_M=2, COMMIT=3.
REQ-021 In RUN: run_en=1, blank=0. A mode press copies cur_* into shadow registers and enters SET_H.
REQ-022 In SET_H/SET_M: run_en=0. A mode press goes SET_H->SET_M or SET_M->COMMIT.
REQ-023 In SET_H, an inc press advances shadow hour (H1,H2) 00..11, with 11->00; the minutes are untouched.
REQ-024 In SET_M, an inc press advances shadow minute (M1,M2) 00..59, with 59->00; the hour is untouched.
REQ-025 COMMIT SHALL last exactly one cycle: load=1, ld_*=shadow, then RUN on the next cycle; load is 0 in every other state.
REQ-026 ld_* SHALL always present the shadow registers.
REQ-027 SHALL blink in set states: blank bits for the digits being set (SET_H: bits0-1, SET_M: bits2-3) toggle every BLINK_MS ms; other bits stay 0.
REQ-028 Every inc press SHALL restart the blink phase visible (bits 0).
REQ-029 SHALL maintain an idle counter in ms, cleared on any press; on reaching TIMEOUT_MS in SET_H/SET_M -> RUN, no load, live time resumes.
REQ-030 If mode and inc pulses coincide, mode SHALL win and inc is discarded.
REQ-031 Presses in COMMIT SHALL be ignored.
REQ-032 The ms counters SHALL advance only on tick_1khz and SHALL be sized for TIMEOUT_MS without wrap.

Reset
REQ-033 When Reset=0 at a posedge, state SHALL become RUN, run_en=1, load=0, blank=0, mode=0, shadow=00:00, and all counters, synchronizers and debounced levels 0.
REQ-034 A Reset mid-set SHALL abandon the edit with no load pulse.

Structure
REQ-035 Package clk_ctrl_pkg SHALL hold the state enum/codes, the DEB_MS/BLINK_MS/TIMEOUT_MS/RPT_* defaults, and the blank bit indices.
REQ-036 Sub-module btn_debounce (sync + stable-count + rise pulse) SHALL be instantiated twice; repeat logic applies only to inc.

Verification
REQ-037 Reset low 2 cycles -> mode=0, run_en=1, load=0, blank=6'b0; hold 5 ms, no change.
REQ-038 Time 10:58, mode press, 3 inc presses -> shadow hour 01; 2 more inc presses -> 03; then mode, mode -> single load with ld=03:58, run_en=1.
REQ-039 SET_M at 58, inc held 1500 ms -> pulses at 0, 500, 700, 900, 1100, 1300 ms; minute 58->59->00->01->02->03->04.
REQ-040 Glitch of 10 ms on btn_mode -> no press; 25 ms press -> exactly one press pulse.
REQ-041 SET_H idle 10000 ms -> RUN, load never asserted; blank bits0-1 toggle at 250 ms while waiting.
REQ-042 Mode and inc pulses in same cycle from RUN -> SET_H with hour unchanged; Reset asserted in SET_M -> RUN, no load.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg
//   Shared definitions for the time-setting controller: state encoding,
//   default timing parameters (all in milliseconds of the 1 kHz tick),
//   display blank bit positions and the BCD step helpers used to advance
//   the shadow hour and minute.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_H  = 2'd1,
    ST_SET_M  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam int DEB_MS_DEF     = 20;
  localparam int BLINK_MS_DEF   = 250;
  localparam int TIMEOUT_MS_DEF = 10000;
  localparam int RPT_DLY_MS_DEF = 500;
  localparam int RPT_MS_DEF     = 200;

  localparam int BLANK_H1 = 0;
  localparam int BLANK_H2 = 1;
  localparam int BLANK_M1 = 2;
  localparam int BLANK_M2 = 3;
  localparam int BLANK_S1 = 4;
  localparam int BLANK_S2 = 5;

  // Hour is {H1, H2} in BCD on a 12-position dial: 00..11, then back to 00.
  function automatic logic [4:0] next_hour(input logic [4:0] hh);
    logic [4:0] r;
    if (hh == 5'h11) r = 5'h00;
    else if (hh[3:0] == 4'd9) r = 5'h10;
    else r = {hh[4], hh[3:0] + 4'd1};
    return r;
  endfunction

  // Minute is {M1, M2} in BCD: 00..59, then back to 00.
  function automatic logic [6:0] next_minute(input logic [6:0] mm);
    logic [6:0] r;
    if (mm[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[6:4] = (mm[6:4] == 3'd5) ? 3'd0 : mm[6:4] + 3'd1;
    end else begin
      r = {mm[6:4], mm[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Raw push-button conditioning: 2-FF synchronizer, then a stable-sample
//   filter clocked by the 1 kHz tick, then a rising-edge detector.
//   Ports:
//     clk     - system clock
//     rst_n   - synchronous active-low reset
//     tick    - one-cycle 1 kHz sample strobe
//     btn_raw - asynchronous active-high button
//     level   - debounced button level
//     rise    - one-cycle pulse when level goes 0->1 (aligned with level)
module btn_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_MS + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the run.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB_MS - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Two-button clock time setting. Mode steps RUN -> SET_H -> SET_M ->
//   COMMIT -> RUN; inc advances the digits being edited (with auto-repeat
//   while held). The digits being edited blink; an idle set state falls
//   back to RUN without loading.
//   Ports:
//     MHz                        - 10 MHz system clock
//     Reset                      - synchronous active-low reset
//     tick_1khz                  - one-cycle 1 kHz strobe
//     btn_mode, btn_inc          - raw asynchronous buttons
//     cur_h1/h2/m1/m2            - live time digits
//     run_en                     - time counter count enable
//     load                       - one-cycle load strobe
//     ld_h1/h2/m1/m2             - shadow time to load
//     blank[5:0]                 - per-digit blank (H1,H2,M1,M2,S1,S2)
//     mode[1:0]                  - current state code
module time_set_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DEB_MS     = DEB_MS_DEF,
  parameter int BLINK_MS   = BLINK_MS_DEF,
  parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
  parameter int RPT_DLY_MS = RPT_DLY_MS_DEF,
  parameter int RPT_MS     = RPT_MS_DEF
) (
  input  logic       MHz,
  input  logic       Reset,
  input  logic       tick_1khz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       cur_h1,
  input  logic [3:0] cur_h2,
  input  logic [2:0] cur_m1,
  input  logic [3:0] cur_m2,
  output logic       run_en,
  output logic       load,
  output logic       ld_h1,
  output logic [3:0] ld_h2,
  output logic [2:0] ld_m1,
  output logic [3:0] ld_m2,
  output logic [5:0] blank,
  output logic [1:0] mode
);

  localparam int IDLE_W  = $clog2(TIMEOUT_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_MS + 1);
  localparam int RPT_MAX = (RPT_DLY_MS > RPT_MS) ? RPT_DLY_MS : RPT_MS;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic mode_level_unused, mode_rise;
  logic inc_level, inc_rise;

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
    .clk(MHz), .rst_n(Reset), .tick(tick_1khz), .btn_raw(btn_mode),
    .level(mode_level_unused), .rise(mode_rise)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_inc (
    .clk(MHz), .rst_n(Reset), .tick(tick_1khz), .btn_raw(btn_inc),
    .level(inc_level), .rise(inc_rise)
  );

  state_e               state_q, state_d;
  logic [4:0]           hour_q, hour_d;
  logic [6:0]           min_q, min_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_ph_q, blink_ph_d;
  logic [RPT_W-1:0]     rpt_cnt_q, rpt_cnt_d;
  logic                 rpt_on_q, rpt_on_d;
  logic                 rpt_pulse_q, rpt_pulse_d;

  logic mode_p, inc_p, any_press, in_set, timeout;

  // Auto-repeat: first extra pulse RPT_DLY_MS after the press, then every
  // RPT_MS, for as long as the debounced inc level stays high.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_on_d    = rpt_on_q;
    rpt_pulse_d = 1'b0;
    if (!inc_level || inc_rise) begin
      rpt_cnt_d = '0;
      rpt_on_d  = 1'b0;
    end else if (tick_1khz) begin
      if (!rpt_on_q && rpt_cnt_q == RPT_W'(RPT_DLY_MS - 1)) begin
        rpt_pulse_d = 1'b1;
        rpt_cnt_d   = '0;
        rpt_on_d    = 1'b1;
      end else if (rpt_on_q && rpt_cnt_q == RPT_W'(RPT_MS - 1)) begin
        rpt_pulse_d = 1'b1;
        rpt_cnt_d   = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  // Mode wins over a coincident inc; idle and blink timers only run while
  // editing and restart on any press so the edited digits show immediately.
  always_comb begin
    mode_p    = mode_rise;
    inc_p     = (inc_rise | rpt_pulse_q) & ~mode_rise;
    any_press = mode_rise | inc_rise | rpt_pulse_q;
    in_set    = (state_q == ST_SET_H) || (state_q == ST_SET_M);
    timeout   = in_set && (idle_q == IDLE_W'(TIMEOUT_MS));

    idle_d      = idle_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!in_set || any_press) begin
      idle_d      = '0;
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (tick_1khz) begin
      if (idle_q != IDLE_W'(TIMEOUT_MS)) idle_d = idle_q + 1'b1;
      if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    run_en  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_en = 1'b1;
        if (mode_p) begin
          hour_d  = {cur_h1, cur_h2};
          min_d   = {cur_m1, cur_m2};
          state_d = ST_SET_H;
        end
      end
      ST_SET_H: begin
        if (mode_p) state_d = ST_SET_M;
        else if (timeout) state_d = ST_RUN;
        else if (inc_p) hour_d = next_hour(hour_q);
      end
      ST_SET_M: begin
        if (mode_p) state_d = ST_COMMIT;
        else if (timeout) state_d = ST_RUN;
        else if (inc_p) min_d = next_minute(min_q);
      end
      ST_COMMIT: begin
        load    = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    blank           = '0;
    blank[BLANK_S1] = 1'b0;
    blank[BLANK_S2] = 1'b0;
    if (state_q == ST_SET_H) begin
      blank[BLANK_H1] = blink_ph_q;
      blank[BLANK_H2] = blink_ph_q;
    end else if (state_q == ST_SET_M) begin
      blank[BLANK_M1] = blink_ph_q;
      blank[BLANK_M2] = blink_ph_q;
    end
  end

  always_ff @(posedge MHz) begin
    if (!Reset) begin
      state_q     <= ST_RUN;
      hour_q      <= '0;
      min_q       <= '0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      rpt_cnt_q   <= '0;
      rpt_on_q    <= 1'b0;
      rpt_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_on_q    <= rpt_on_d;
      rpt_pulse_q <= rpt_pulse_d;
    end
  end

  assign ld_h1 = hour_q[4];
  assign ld_h2 = hour_q[3:0];
  assign ld_m1 = min_q[6:4];
  assign ld_m2 = min_q[3:0];
  assign mode  = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl
//   Directed bench for time_set_ctrl with default parameters. The 1 kHz tick
//   is compressed to one strobe every two clocks, so 1 ms = 2 clock cycles.
module tb_time_set_ctrl;

  logic       MHz, Reset, tick_1khz, btn_mode, btn_inc;
  logic       cur_h1;
  logic [3:0] cur_h2;
  logic [2:0] cur_m1;
  logic [3:0] cur_m2;
  logic       run_en, load;
  logic       ld_h1;
  logic [3:0] ld_h2;
  logic [2:0] ld_m1;
  logic [3:0] ld_m2;
  logic [5:0] blank;
  logic [1:0] mode;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int load_cnt = 0;
  logic [4:0] load_hour = '0;
  logic [6:0] load_min = '0;

  wire [4:0] sh_hour = {ld_h1, ld_h2};
  wire [6:0] sh_min  = {ld_m1, ld_m2};

  time_set_ctrl dut (
    .MHz(MHz), .Reset(Reset), .tick_1khz(tick_1khz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h1(cur_h1), .cur_h2(cur_h2), .cur_m1(cur_m1), .cur_m2(cur_m2),
    .run_en(run_en), .load(load),
    .ld_h1(ld_h1), .ld_h2(ld_h2), .ld_m1(ld_m1), .ld_m2(ld_m2),
    .blank(blank), .mode(mode)
  );

  initial begin
    MHz = 1'b0;
    forever #50 MHz = ~MHz;
  end

  initial begin
    tick_1khz = 1'b0;
    forever @(negedge MHz) tick_1khz = ~tick_1khz;
  end

  always @(posedge MHz) cyc <= cyc + 1;

  // Counts load strobes and records the value offered with each one.
  always @(posedge MHz) begin
    #1;
    if (load === 1'b1) begin
      load_cnt  = load_cnt + 1;
      load_hour = sh_hour;
      load_min  = sh_min;
    end
  end

  task automatic wait_ms(input int ms);
    repeat (ms * 2) @(negedge MHz);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge MHz);
  endtask

  task automatic set_cur(input logic [4:0] hh, input logic [6:0] mm);
    cur_h1 = hh[4];
    cur_h2 = hh[3:0];
    cur_m1 = mm[6:4];
    cur_m2 = mm[3:0];
  endtask

  task automatic tap_mode();
    btn_mode = 1'b1;
    wait_ms(30);
    btn_mode = 1'b0;
    wait_ms(30);
  endtask

  task automatic tap_inc();
    btn_inc = 1'b1;
    wait_ms(30);
    btn_inc = 1'b0;
    wait_ms(30);
  endtask

  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge MHz);
    Reset = 1'b0;
    repeat (2) @(negedge MHz);
    Reset = 1'b1;
    wait_ms(2);
  endtask

  task automatic test_reset();
    set_cur(5'h10, 7'h58);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge MHz);
    Reset = 1'b0;
    repeat (2) @(negedge MHz);
    total++;
    if ({mode, run_en, load, blank} !== {2'd0, 1'b1, 1'b0, 6'd0}) begin
      bad++;
      $display("[TB] FAIL reset_outputs: mode=%0d run_en=%b load=%b blank=%b, want 0 1 0 000000",
               mode, run_en, load, blank);
    end
    total++;
    if ({sh_hour, sh_min} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_shadow: got %h:%h want 00:00", sh_hour, sh_min);
    end
    Reset = 1'b1;
    wait_ms(5);
    total++;
    if ({mode, run_en, load, blank} !== {2'd0, 1'b1, 1'b0, 6'd0} || load_cnt !== 0) begin
      bad++;
      $display("[TB] FAIL reset_hold: mode=%0d run_en=%b load=%b blank=%b loads=%0d, want 0 1 0 000000 0",
               mode, run_en, load, blank, load_cnt);
    end
  endtask

  task automatic test_set_sequence();
    int loads0;
    do_reset();
    set_cur(5'h10, 7'h58);
    loads0 = load_cnt;
    tap_mode();
    total++;
    if (mode !== 2'd1 || run_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL seq_enter_set_h: mode=%0d run_en=%b want 1 0", mode, run_en);
    end
    total++;
    if (sh_hour !== 5'h10 || sh_min !== 7'h58) begin
      bad++;
      $display("[TB] FAIL seq_copy: got %h:%h want 10:58", sh_hour, sh_min);
    end
    repeat (3) tap_inc();
    total++;
    if (sh_hour !== 5'h01 || sh_min !== 7'h58) begin
      bad++;
      $display("[TB] FAIL seq_hour_wrap: got %h:%h want 01:58", sh_hour, sh_min);
    end
    repeat (2) tap_inc();
    total++;
    if (sh_hour !== 5'h03) begin
      bad++;
      $display("[TB] FAIL seq_hour_03: got %h want 03", sh_hour);
    end
    tap_mode();
    total++;
    if (mode !== 2'd2 || load_cnt !== loads0) begin
      bad++;
      $display("[TB] FAIL seq_enter_set_m: mode=%0d loads=%0d want 2 %0d", mode, load_cnt, loads0);
    end
    tap_mode();
    total++;
    if (load_cnt - loads0 !== 1) begin
      bad++;
      $display("[TB] FAIL seq_load_count: got %0d want 1", load_cnt - loads0);
    end
    total++;
    if (load_hour !== 5'h03 || load_min !== 7'h58) begin
      bad++;
      $display("[TB] FAIL seq_load_value: got %h:%h want 03:58", load_hour, load_min);
    end
    total++;
    if (mode !== 2'd0 || run_en !== 1'b1 || load !== 1'b0) begin
      bad++;
      $display("[TB] FAIL seq_back_run: mode=%0d run_en=%b load=%b want 0 1 0", mode, run_en, load);
    end
  endtask

  task automatic test_auto_repeat();
    int off[6] = '{250, 600, 800, 1000, 1200, 1400};
    logic [6:0] exp_min[6] = '{7'h59, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04};
    int n;
    int t0;
    do_reset();
    set_cur(5'h10, 7'h58);
    tap_mode();
    tap_mode();
    total++;
    if (mode !== 2'd2 || sh_min !== 7'h58) begin
      bad++;
      $display("[TB] FAIL rpt_setup: mode=%0d min=%h want 2 58", mode, sh_min);
    end
    btn_inc = 1'b1;
    n = 0;
    while (sh_min !== 7'h59 && n < 100) begin
      @(negedge MHz);
      n++;
    end
    total++;
    if (sh_min !== 7'h59) begin
      bad++;
      $display("[TB] FAIL rpt_first_press: min=%h want 59 within 100 cycles", sh_min);
    end
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      wait_until(t0 + 2 * off[i]);
      total++;
      if (sh_min !== exp_min[i]) begin
        bad++;
        $display("[TB] FAIL rpt_at_%0dms: min=%h want %h", off[i], sh_min, exp_min[i]);
      end
    end
    btn_inc = 1'b0;
    wait_until(t0 + 2 * 1700);
    total++;
    if (sh_min !== 7'h04 || sh_hour !== 5'h10) begin
      bad++;
      $display("[TB] FAIL rpt_after_release: got %h:%h want 10:04", sh_hour, sh_min);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btn_mode = 1'b1;
    wait_ms(10);
    btn_mode = 1'b0;
    wait_ms(40);
    total++;
    if (mode !== 2'd0) begin
      bad++;
      $display("[TB] FAIL glitch_10ms: mode=%0d want 0", mode);
    end
    btn_mode = 1'b1;
    wait_ms(25);
    btn_mode = 1'b0;
    wait_ms(40);
    total++;
    if (mode !== 2'd1) begin
      bad++;
      $display("[TB] FAIL press_25ms: mode=%0d want 1", mode);
    end
  endtask

  task automatic test_timeout();
    int blink_off[4] = '{125, 375, 625, 875};
    logic [5:0] blink_exp[4] = '{6'b000000, 6'b000011, 6'b000000, 6'b000011};
    int loads0;
    int n;
    int t0;
    do_reset();
    set_cur(5'h07, 7'h15);
    loads0 = load_cnt;
    btn_mode = 1'b1;
    n = 0;
    while (mode !== 2'd1 && n < 100) begin
      @(negedge MHz);
      n++;
    end
    total++;
    if (mode !== 2'd1) begin
      bad++;
      $display("[TB] FAIL to_enter: mode=%0d want 1 within 100 cycles", mode);
    end
    t0 = cyc;
    wait_until(t0 + 60);
    btn_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_until(t0 + 2 * blink_off[i]);
      total++;
      if (blank !== blink_exp[i]) begin
        bad++;
        $display("[TB] FAIL blink_at_%0dms: blank=%b want %b", blink_off[i], blank, blink_exp[i]);
      end
    end
    wait_until(t0 + 2 * 9900);
    total++;
    if (mode !== 2'd1 || run_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL to_early: mode=%0d run_en=%b want 1 0 at 9900ms", mode, run_en);
    end
    while (mode !== 2'd0 && cyc < t0 + 2 * 10100) @(negedge MHz);
    total++;
    if (mode !== 2'd0 || (cyc - t0) < 19990 || (cyc - t0) > 20010) begin
      bad++;
      $display("[TB] FAIL to_expire: mode=%0d after %0d cycles, want 0 after 19990..20010",
               mode, cyc - t0);
    end
    total++;
    if (load_cnt !== loads0 || run_en !== 1'b1 || blank !== 6'd0) begin
      bad++;
      $display("[TB] FAIL to_no_load: loads=%0d run_en=%b blank=%b want %0d 1 000000",
               load_cnt, run_en, blank, loads0);
    end
  endtask

  task automatic test_coincide_and_reset();
    int loads0;
    do_reset();
    set_cur(5'h10, 7'h58);
    loads0 = load_cnt;
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    wait_ms(30);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_ms(30);
    total++;
    if (mode !== 2'd1 || sh_hour !== 5'h10 || sh_min !== 7'h58) begin
      bad++;
      $display("[TB] FAIL both_from_run: mode=%0d %h:%h want 1 10:58", mode, sh_hour, sh_min);
    end
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    wait_ms(30);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_ms(30);
    total++;
    if (mode !== 2'd2 || sh_hour !== 5'h10) begin
      bad++;
      $display("[TB] FAIL both_in_set_h: mode=%0d hour=%h want 2 10", mode, sh_hour);
    end
    @(negedge MHz);
    Reset = 1'b0;
    repeat (2) @(negedge MHz);
    Reset = 1'b1;
    wait_ms(5);
    total++;
    if (mode !== 2'd0 || run_en !== 1'b1 || blank !== 6'd0 || load_cnt !== loads0) begin
      bad++;
      $display("[TB] FAIL reset_mid_set: mode=%0d run_en=%b blank=%b loads=%0d want 0 1 000000 %0d",
               mode, run_en, blank, load_cnt, loads0);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    set_cur(5'h00, 7'h00);
    $display("[TB] start");
    test_reset();
    test_set_sequence();
    test_auto_repeat();
    test_glitch();
    test_timeout();
    test_coincide_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
